// File: rtl/mac_sched.sv
// mac_sched: round-robin scheduler sharing one 2-stage MAC between two dot-product requesters.
// Optional stall watchdog is compiled in when MAC_SCHED_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module mac_sched #(
  parameter int LEN_W     = 8,
  parameter int DRAIN_CYC = 2,
  parameter int TO_CYC    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       a0,
  input  logic [7:0]       b0,
  input  logic [7:0]       a1,
  input  logic [7:0]       b1,
  input  logic [1:0]       vld,
  output logic [1:0]       rdy,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             mac_en,
  output logic             mac_clr,
  output logic [7:0]       mac_A,
  output logic [7:0]       mac_B,
  input  logic [63:0]      mac_accum,
  output logic [63:0]      result,
  output logic [1:0]       done
`ifdef MAC_SCHED_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  if (DRAIN_CYC < 2 || TO_CYC < 2) begin : g_bad_param
    $error("mac_sched: DRAIN_CYC and TO_CYC must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

  localparam int            DW    = $clog2(DRAIN_CYC);
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYC - 1);

  state_t           state, nxt;
  logic             sel, last, pick, hs, stall_out;
  logic [LEN_W-1:0] cnt;
  logic [DW-1:0]    dcnt;

  // Ties go to the requester that was not served last.
  assign pick = (req == 2'b11) ? ~last : req[1];
  assign hs   = (state == RUN) && vld[sel];

`ifdef MAC_SCHED_TIMEOUT_EN
  localparam int            SW    = $clog2(TO_CYC);
  localparam logic [SW-1:0] SLAST = SW'(TO_CYC - 1);

  logic [SW-1:0] stall;
  logic          to_flag;

  assign stall_out = (state == RUN) && !hs && (stall == SLAST);
  assign timeout   = (state == DONE) && to_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall   <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == RUN && !hs) stall <= stall + SW'(1);
      else                     stall <= '0;
      if (stall_out)           to_flag <= 1'b1;
      else if (state == DONE)  to_flag <= 1'b0;
    end
  end
`else
  assign stall_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      dcnt   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          sel <= pick;
          cnt <= pick ? len1 : len0;
        end
        RUN: if (hs) cnt <= cnt - LEN_W'(1);
        DRAIN: begin
          if (dcnt == DLAST) begin
            dcnt   <= '0;
            result <= mac_accum;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE: last <= sel;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (|req) nxt = CLR;
      CLR:   nxt = (cnt != '0) ? RUN : DRAIN;
      RUN:   if ((hs && cnt == LEN_W'(1)) || stall_out) nxt = DRAIN;
      DRAIN: if (dcnt == DLAST) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy     = '0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    mac_A   = '0;
    mac_B   = '0;
    done    = '0;
    busy    = (state != IDLE);
    gnt     = busy ? (sel ? 2'b10 : 2'b01) : 2'b00;
    case (state)
      CLR: mac_clr = 1'b1;
      RUN: begin
        rdy[sel] = 1'b1;
        if (vld[sel]) begin
          mac_en = 1'b1;
          mac_A  = sel ? a1 : a0;
          mac_B  = sel ? b1 : b0;
        end
      end
      DONE: done[sel] = 1'b1;
      default: ;
    endcase
  end

endmodule
